// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single data-memory port between the core (priority requester)
//   and a DMA/host loader. A DMA requester that is denied MAX_WAIT cycles in a
//   row gets one forced slot. Write data is presented on bc_dt one cycle after
//   the write command, because the memory commits at command+1. Read data
//   returns one cycle after the read command and is steered by an owner tag.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   core_dm_cslt/wrb/add/wdata    core request (held while core_stall=1)
//   core_stall                    core request not taken this cycle
//   core_rd_valid/core_rd_data    core read return
//   dma_req/wrb/add/wdata         DMA request (held until dma_gnt)
//   dma_gnt                       DMA request taken this cycle
//   dma_rd_valid/dma_rd_data      DMA read return
//   ps_dm_cslt/ps_dm_wrb          memory chip select / write strobe
//   dg_dm_add                     memory address
//   bc_dt                         memory write / bypass data
//   dm_bc_dt                      memory read data (registered in memory)
module dm_port_arbiter #(
    parameter int DMA_SIZE = 17,
    parameter int DMD_SIZE = 16,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                core_dm_cslt,
    input  logic                core_dm_wrb,
    input  logic [DMA_SIZE-1:0] core_dm_add,
    input  logic [DMD_SIZE-1:0] core_dm_wdata,
    output logic                core_stall,
    output logic                core_rd_valid,
    output logic [DMD_SIZE-1:0] core_rd_data,
    input  logic                dma_req,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_add,
    input  logic [DMD_SIZE-1:0] dma_wdata,
    output logic                dma_gnt,
    output logic                dma_rd_valid,
    output logic [DMD_SIZE-1:0] dma_rd_data,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_e;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    op_e                 prev_op_q,  prev_op_d;
    logic [DMD_SIZE-1:0] wdata_q;
    logic [DMD_SIZE-1:0] shadow_q;
    logic [DMA_SIZE-1:0] add_q;
    logic                core_rd_q, dma_rd_q;

    logic                force_dma, sel_core, sel_dma, cmd, cmd_wrb;
    logic [DMA_SIZE-1:0] cmd_add;
    logic [DMD_SIZE-1:0] cmd_wdata;
    logic [DMD_SIZE-1:0] bc_mux;

    // Selection: a forced DMA slot overrides the core, otherwise core first.
    always_comb begin
        force_dma = dma_req && (wait_cnt_q == WAIT_MAX);
        sel_dma   = force_dma || (!core_dm_cslt && dma_req);
        sel_core  = !force_dma && core_dm_cslt;
        cmd       = sel_dma || sel_core;
        cmd_wrb   = sel_dma ? dma_wrb   : core_dm_wrb;
        cmd_add   = sel_dma ? dma_add   : core_dm_add;
        cmd_wdata = sel_dma ? dma_wdata : core_dm_wdata;
    end

    // bc_dt always reflects the current contents of the address the memory
    // latched last cycle, so its previous-address bypass returns fresh data.
    always_comb begin
        bc_mux = shadow_q;
        case (prev_op_q)
            OP_WR:   bc_mux = wdata_q;
            OP_RD:   bc_mux = dm_bc_dt;
            default: bc_mux = shadow_q;
        endcase
    end

    always_comb begin
        wait_cnt_d = '0;
        if (dma_req && !sel_dma)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_ONE;
        prev_op_d = !cmd ? OP_IDLE : (cmd_wrb ? OP_WR : OP_RD);
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        ps_dm_cslt    = rst_n && cmd;
        ps_dm_wrb     = rst_n && cmd && cmd_wrb;
        dma_gnt       = rst_n && sel_dma;
        core_stall    = rst_n && force_dma && core_dm_cslt;
        dg_dm_add     = !rst_n ? '0 : (cmd ? cmd_add : add_q);
        bc_dt         = rst_n ? bc_mux : '0;
        core_rd_valid = rst_n && core_rd_q;
        dma_rd_valid  = rst_n && dma_rd_q;
        core_rd_data  = core_rd_valid ? dm_bc_dt : '0;
        dma_rd_data   = dma_rd_valid  ? dm_bc_dt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            prev_op_q  <= OP_IDLE;
            wdata_q    <= '0;
            shadow_q   <= '0;
            add_q      <= '0;
            core_rd_q  <= 1'b0;
            dma_rd_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            prev_op_q  <= prev_op_d;
            shadow_q   <= bc_dt;
            if (cmd && cmd_wrb) wdata_q <= cmd_wdata;
            if (cmd)            add_q   <= cmd_add;
            core_rd_q  <= sel_core && !core_dm_wrb;
            dma_rd_q   <= sel_dma && !dma_wrb;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a memory model with registered reads, commit at
// command+1 and a previous-address bypass, a spec-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dm_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 16;
    localparam int MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_dm_cslt, core_dm_wrb;
    logic [AW-1:0] core_dm_add;
    logic [DW-1:0] core_dm_wdata;
    logic          core_stall, core_rd_valid;
    logic [DW-1:0] core_rd_data;
    logic          dma_req, dma_wrb;
    logic [AW-1:0] dma_add;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rd_valid;
    logic [DW-1:0] dma_rd_data;
    logic          ps_dm_cslt, ps_dm_wrb;
    logic [AW-1:0] dg_dm_add;
    logic [DW-1:0] bc_dt;
    logic [DW-1:0] dm_bc_dt;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_dm_cslt(core_dm_cslt), .core_dm_wrb(core_dm_wrb),
        .core_dm_add(core_dm_add), .core_dm_wdata(core_dm_wdata),
        .core_stall(core_stall), .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
        .dma_req(dma_req), .dma_wrb(dma_wrb), .dma_add(dma_add), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
        .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb), .dg_dm_add(dg_dm_add),
        .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt)
    );

    // ---------------- memory model (environment) ----------------
    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] lat_addr = '0;
    logic          lat_wr = 1'b0;

    always @(posedge clk) begin
        if (ps_dm_cslt && !ps_dm_wrb)
            dm_bc_dt <= (dg_dm_add == lat_addr) ? bc_dt : mem[dg_dm_add[7:0]];
        if (lat_wr) mem[lat_addr[7:0]] = bc_dt;
        lat_addr <= dg_dm_add;
        lat_wr   <= ps_dm_cslt && ps_dm_wrb;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:255];
    int            m_wait = 0;
    logic [AW-1:0] m_last = '0;
    logic          mc_pend = 1'b0, md_pend = 1'b0;
    logic [DW-1:0] mc_exp = '0, md_exp = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[3] = 16'h00AA;  ref_mem[3] = 16'h00AA;
        mem[16] = 16'h0F10; ref_mem[16] = 16'h0F10;
        mem[17] = 16'h0F11; ref_mem[17] = 16'h0F11;
        dm_bc_dt = '0;
    end

    // 0 = idle, 1 = core, 2 = DMA
    function automatic int msel(input logic c, input logic d, input int w);
        if (d && w >= MAX_WAIT) return 2;
        if (c) return 1;
        if (d) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wait = 0; m_last = '0; mc_pend = 1'b0; md_pend = 1'b0;
        end else begin
            int s;
            logic w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            s = msel(core_dm_cslt, dma_req, m_wait);
            w = (s == 2) ? dma_wrb : core_dm_wrb;
            a = (s == 2) ? dma_add : core_dm_add;
            d = (s == 2) ? dma_wdata : core_dm_wdata;
            mc_pend = (s == 1) && !w;
            md_pend = (s == 2) && !w;
            if (s != 0 && !w) begin
                mc_exp = ref_mem[a[7:0]];
                md_exp = ref_mem[a[7:0]];
            end
            if (s != 0 && w) ref_mem[a[7:0]] = d;
            if (s != 0) m_last = a;
            if (dma_req && s != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else m_wait = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int s;
            s = msel(core_dm_cslt, dma_req, m_wait);
            if (!rst_n) begin
                chk("rst_cslt", ps_dm_cslt, 0);
                chk("rst_wrb", ps_dm_wrb, 0);
                chk("rst_gnt", dma_gnt, 0);
                chk("rst_stall", core_stall, 0);
                chk("rst_add", dg_dm_add, 0);
                chk("rst_bc", bc_dt, 0);
                chk("rst_crv", core_rd_valid, 0);
                chk("rst_drv", dma_rd_valid, 0);
            end else begin
                chk("m_cslt", ps_dm_cslt, s != 0);
                chk("m_wrb", ps_dm_wrb, (s == 1) ? core_dm_wrb : (s == 2) ? dma_wrb : 1'b0);
                chk("m_add", dg_dm_add, (s == 1) ? core_dm_add : (s == 2) ? dma_add : m_last);
                chk("m_gnt", dma_gnt, s == 2);
                chk("m_stall", core_stall, (s == 2) && core_dm_cslt);
                chk("m_bc", bc_dt, ref_mem[m_last[7:0]]);
                chk("m_crv", core_rd_valid, mc_pend);
                chk("m_drv", dma_rd_valid, md_pend);
                if (mc_pend) chk("m_cdata", core_rd_data, mc_exp);
                if (md_pend) chk("m_ddata", dma_rd_data, md_exp);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic c, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic d, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        core_dm_cslt = c; core_dm_wrb = cw; core_dm_add = ca; core_dm_wdata = cd;
        dma_req = d; dma_wrb = dw; dma_add = da; dma_wdata = dd;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Inputs change 1ns after the edge; literal checks land 2ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
    end

    initial begin
        rst_n = 1'b0;
        drive(1, 0, 17'h00007, '0, 1, 0, 17'h00009, '0);
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("reset_cslt", ps_dm_cslt, 0);
            chk("reset_gnt", dma_gnt, 0);
            chk("reset_stall", core_stall, 0);
            chk("reset_bc", bc_dt, 0);
            chk("reset_rv", {core_rd_valid, dma_rd_valid}, 0);
            step();
        end
        rst_n = 1'b1; idle();
        step();

        // core write then read-back of the same address
        drive(1, 1, 17'h0000A, 16'h1234, 0, 0, '0, '0); #2;
        chk("cw_cslt", ps_dm_cslt, 1);
        chk("cw_wrb", ps_dm_wrb, 1);
        chk("cw_add", dg_dm_add, 17'h0000A);
        step();
        drive(1, 0, 17'h0000A, '0, 0, 0, '0, '0); #2;
        chk("cw_bc", bc_dt, 16'h1234);
        chk("cr_wrb", ps_dm_wrb, 0);
        step();
        idle(); #2;
        chk("cr_valid", core_rd_valid, 1);
        chk("cr_data", core_rd_data, 16'h1234);
        step();

        // DMA read with core idle
        drive(0, 0, '0, '0, 1, 0, 17'h00003, '0); #2;
        chk("dr_gnt", dma_gnt, 1);
        step();
        idle(); #2;
        chk("dr_valid", dma_rd_valid, 1);
        chk("dr_data", dma_rd_data, 16'h00AA);
        chk("dr_core_quiet", core_rd_valid, 0);
        step();

        // starvation: core reads every cycle, DMA forced in at cycle 8
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 17'h00010, '0, k <= 8, 0, 17'h00011, '0); #2;
            chk("st_gnt", dma_gnt, k == 8);
            chk("st_stall", core_stall, k == 8);
            if (k == 9) begin
                chk("st_resume_add", dg_dm_add, 17'h00010);
                chk("st_wait_clr", dut.wait_cnt_q, 0);
                chk("st_dma_rv", dma_rd_valid, 1);
                chk("st_dma_data", dma_rd_data, 16'h0F11);
                chk("st_core_rv", core_rd_valid, 0);
            end
            step();
        end
        idle(); step();

        // back-to-back writes from both requesters
        drive(1, 1, 17'h00001, 16'h1111, 0, 0, '0, '0); step();
        drive(0, 0, '0, '0, 1, 1, 17'h00002, 16'h2222); #2;
        chk("bb_gnt", dma_gnt, 1);
        chk("bb_bc1", bc_dt, 16'h1111);
        step();
        drive(1, 0, 17'h00001, '0, 0, 0, '0, '0); #2;
        chk("bb_bc2", bc_dt, 16'h2222);
        step();
        drive(1, 0, 17'h00002, '0, 0, 0, '0, '0); #2;
        chk("bb_rd1", core_rd_data, 16'h1111);
        step();
        idle(); #2;
        chk("bb_rd2", core_rd_data, 16'h2222);
        step();

        // bypass consistency: write, idle gap, two reads of the same address
        drive(1, 1, 17'h00005, 16'hBEEF, 0, 0, '0, '0); step();
        idle(); step(); step(); step();
        drive(1, 0, 17'h00005, '0, 0, 0, '0, '0); step();
        drive(1, 0, 17'h00005, '0, 0, 0, '0, '0); #2;
        chk("by_rd1", core_rd_data, 16'hBEEF);
        step();
        idle(); #2;
        chk("by_rd2", core_rd_data, 16'hBEEF);
        chk("by_rv2", core_rd_valid, 1);
        step();

        // reset while a read return is pending drops the return
        drive(0, 0, '0, '0, 1, 0, 17'h00003, '0); step();
        rst_n = 1'b0; idle(); #2;
        chk("mr_rv_in_rst", dma_rd_valid, 0);
        step();
        rst_n = 1'b1; #2;
        chk("mr_rv_after", dma_rd_valid, 0);
        chk("mr_bc_after", bc_dt, 0);
        step(); step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
